fifo_sdpram_fwft: RTL and testbench
===================================

// Module: fifo_sdpram_fwft
// PURPOSE
//  Parametrised successor to the CSR-fed byte FIFO: WIDTH-bit words, DEPTH-deep sdpram store
//  plus 2-entry first-word-fall-through output buffer, valid/ready pop side, level/full/overflow
//  status CSR and flush. Sits between the CSR write path (core pushes) and a peripheral consumer
//  (UART TX shifter or similar) that pops one word per cycle at full rate.
// PARAMETERS
//  WIDTH      8                       data word width, 1..32 (rs1_data[WIDTH-1:0] is pushed)
//  DEPTH      16                      sdpram entries; power of two, >=2; total capacity DEPTH+2
//  PUSH_ADDR  FifoPushCsrAddr         CSR address whose write pushes a word
//  STAT_ADDR  FifoStatusCsrAddr       CSR address of the status/control register
// PORTS
//  clk_i         in   1          clock
//  reset_i       in   1          synchronous, active-high reset
//  csr_enable    in   1          CSR access strobe this cycle
//  csr_addr      in   CsrAddrT   CSR address
//  rs1_data      in   word       CSR write data
//  csr_data_out  out  word       status read data; combinational, valid when csr_addr==STAT_ADDR, else 0
//  ready_i       in   1          consumer accepts data_o this cycle
//  valid_o       out  1          data_o holds the head word
//  data_o        out  WIDTH      head word (FWFT)
//  level_o       out  LVL_W      occupancy 0..DEPTH+2, LVL_W=$clog2(DEPTH+3)
//  empty_o       out  1          level_o==0
//  full_o        out  1          level_o==DEPTH+2
//  overflow_o    out  1          sticky: a push was dropped
// BEHAVIOUR
//  - Reset: pointers, level, out-buffer count, in-flight flag and overflow=0; valid_o=0, data_o=0,
//    empty_o=1, full_o=0. Reset mid-transfer discards all content and any in-flight read.
//  - Push: csr_enable && csr_addr==PUSH_ADDR. Accepted iff !full_o (sampled before any same-cycle pop;
//    a push while full is dropped even with a simultaneous pop) -> overflow set.
//  - Pop: valid_o && ready_i; head advances at that edge; ready_i with !valid_o is ignored.
//  - Storage: mem pointers are $clog2(DEPTH)+1 bits; wrap on address bits, mem full when MSBs differ
//    and address bits are equal. sdpram read latency 1 cycle (registered dout).
//  - Prefetch: issue a mem read (rd_ptr++, in_flight=1) when mem non-empty and
//    out_cnt + in_flight - pop < 2; next cycle dout is written into the out buffer. Sustains 1 pop/cycle.
//  - Latency: push in cycle t into empty FIFO -> valid_o high in cycle t+3 (write t, read t+1, load t+2).
//  - level_o = mem_count + in_flight + out_cnt; push and pop in same cycle leave level unchanged.
//  - Status CSR read: [LVL_W-1:0]=level, [16]=empty, [17]=full, [18]=overflow, others 0.
//  - Status CSR write: bit18=1 clears overflow (W1C); bit31=1 flushes (pointers, out buffer,
//    in_flight cleared, valid_o=0 next cycle). Flush does not clear overflow unless bit18 also set.
//  - Simultaneous: a dropped push and a W1C clear in the same cycle cannot occur (single CSR address);
//    a pop in the flush cycle is accepted, then content discarded.
// CONFIGURATION
//  FIFO_BYPASS_EN defined: a push while level==0 and !in_flight writes straight into out buffer
//    slot 0; valid_o high in cycle t+1. A push with out_cnt==1 and mem empty and !in_flight
//    fills slot 1 directly. Ordering is preserved in all cases.
//  Undefined: every word passes through the sdpram; latency t+3 as above.
// STRUCTURE
//  - config_pkg: FifoPushCsrAddr, FifoStatusCsrAddr, FifoStatLevelLsb/EmptyBit/FullBit/OvfBit/FlushBit,
//    typedef fifo_status_t (packed struct matching the status layout).
//  - decoder_pkg: CsrAddrT, word (existing).
//  - Sub-module: existing sdpram_block (FifoSizeBits=WIDTH*DEPTH) as store; no new sub-module.
// TESTING
//  1 Reset then push 0xA5 (ready_i=0) -> valid_o=1,data_o=0xA5 at t+3 (t+1 with FIFO_BYPASS_EN), level_o=1.
//  2 Push 1..DEPTH+2, ready_i=0 -> full_o=1, level=DEPTH+2; push 0x77 -> dropped, overflow_o=1;
//    write STAT 1<<18 -> overflow_o=0.
//  3 Fill DEPTH+2, hold ready_i=1 -> words 1..DEPTH+2 popped on consecutive cycles, then empty_o=1.
//  4 Continuous push+pop every cycle for 3*DEPTH words -> level stays constant, order intact across wrap.
//  5 Fill 5 words, write STAT 1<<31 with a read in flight -> valid_o=0 next cycle, level=0,
//    next push 0x3C is the next word seen.
//  6 Assert reset_i mid-stream -> all outputs at reset values next cycle; old data never reappears.

Source files
------------

// File: rtl/fifo_sdpram_fwft_pkg.sv
// Shared CSR types, FIFO CSR addresses and the status register layout for fifo_sdpram_fwft.
// Status word: [15:0] level, [16] empty, [17] full, [18] overflow (W1C), [31] flush (write-only).
package fifo_sdpram_fwft_pkg;

  typedef logic [11:0] CsrAddrT;
  typedef logic [31:0] word;

  localparam CsrAddrT FifoPushCsrAddr   = 12'h8C0;
  localparam CsrAddrT FifoStatusCsrAddr = 12'h8C1;

  localparam int FifoStatLevelLsb = 0;
  localparam int FifoStatEmptyBit = 16;
  localparam int FifoStatFullBit  = 17;
  localparam int FifoStatOvfBit   = 18;
  localparam int FifoStatFlushBit = 31;

  typedef struct packed {
    logic        flush;
    logic [11:0] rsvd;
    logic        overflow;
    logic        full;
    logic        empty;
    logic [15:0] level;
  } fifo_status_t;

endpackage

// File: rtl/sdpram_block.sv
// Simple dual-port RAM: one write port, one read port with a registered (1-cycle) read.
// A same-address read and write in one cycle returns the old contents.
module sdpram_block #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sdpram_fwft.sv
// CSR-fed FIFO: sdpram store plus a 2-entry first-word-fall-through output buffer.
// Optional `FIFO_BYPASS_EN lets pushes skip the sdpram when nothing is queued ahead in it.
module fifo_sdpram_fwft
  import fifo_sdpram_fwft_pkg::*;
#(
  parameter  int      WIDTH     = 8,
  parameter  int      DEPTH     = 16,
  parameter  CsrAddrT PUSH_ADDR = FifoPushCsrAddr,
  parameter  CsrAddrT STAT_ADDR = FifoStatusCsrAddr,
  localparam int      LVL_W     = $clog2(DEPTH + 3)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             csr_enable,
  input  CsrAddrT          csr_addr,
  input  word              rs1_data,
  output word              csr_data_out,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  // Handshake: a word leaves at the rising edge where valid_o && ready_i; ready_i alone does nothing.
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CAP   = DEPTH + 2;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       out_cnt_q, out_cnt_d, cnt_tmp;
  logic             in_flight_q, in_flight_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_buf_q [2];
  logic [WIDTH-1:0] out_buf_d [2];
  logic [WIDTH-1:0] mem_rdata;
  logic [PTR_W-1:0] mem_count;
  logic [LVL_W-1:0] level;
  logic             push_req, push_ok, stat_wr, flush, ovf_clr, pop;
  logic             mem_empty, rd_issue, bypass, mem_we, full;
  logic             unused_rs1;
  fifo_status_t     status;

  assign push_req = csr_enable && (csr_addr == PUSH_ADDR);
  assign stat_wr  = csr_enable && (csr_addr == STAT_ADDR);
  assign flush    = stat_wr && rs1_data[FifoStatFlushBit];
  assign ovf_clr  = stat_wr && rs1_data[FifoStatOvfBit];
  assign pop      = valid_o && ready_i;

  assign mem_count = wr_ptr_q - rd_ptr_q;
  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign level     = LVL_W'(mem_count) + LVL_W'(in_flight_q) + LVL_W'(out_cnt_q);
  assign full      = (level == LVL_W'(CAP));
  // Fullness is judged before any same-cycle pop, so a push against a full FIFO is always lost.
  assign push_ok   = push_req && !full;

  // Keep at most two words between the out buffer and the read in flight.
  assign rd_issue = !mem_empty &&
                    (({1'b0, out_cnt_q} + {2'b0, in_flight_q}) < (3'd2 + {2'b0, pop}));

`ifdef FIFO_BYPASS_EN
  assign bypass = push_ok && mem_empty && !in_flight_q && (out_cnt_q != 2'd2);
`else
  assign bypass = 1'b0;
`endif
  assign mem_we = push_ok && !bypass;

  sdpram_block #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (rs1_data[WIDTH-1:0]),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(mem_we);
    rd_ptr_d    = rd_ptr_q + PTR_W'(rd_issue);
    in_flight_d = rd_issue;
    out_buf_d   = out_buf_q;
    cnt_tmp     = out_cnt_q;
    ovf_d       = ovf_q;
    if (pop) begin
      out_buf_d[0] = out_buf_q[1];
      cnt_tmp      = cnt_tmp - 2'd1;
    end
    // The prefetch rule guarantees at most one slot is occupied here, so cnt_tmp[0] is the free slot.
    if (in_flight_q) begin
      out_buf_d[cnt_tmp[0]] = mem_rdata;
      cnt_tmp               = cnt_tmp + 2'd1;
    end
    if (bypass) begin
      out_buf_d[cnt_tmp[0]] = rs1_data[WIDTH-1:0];
      cnt_tmp               = cnt_tmp + 2'd1;
    end
    out_cnt_d = cnt_tmp;
    if (push_req && full) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      in_flight_d  = 1'b0;
      out_cnt_d    = '0;
      out_buf_d[0] = '0;
      out_buf_d[1] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_flight_q  <= 1'b0;
      out_cnt_q    <= '0;
      out_buf_q[0] <= '0;
      out_buf_q[1] <= '0;
      ovf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_flight_q  <= in_flight_d;
      out_cnt_q    <= out_cnt_d;
      out_buf_q[0] <= out_buf_d[0];
      out_buf_q[1] <= out_buf_d[1];
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    status          = '0;
    status.level    = 16'(level);
    status.empty    = (level == '0);
    status.full     = full;
    status.overflow = ovf_q;
  end

  assign csr_data_out = (csr_addr == STAT_ADDR) ? word'(status) : '0;
  assign valid_o      = (out_cnt_q != 2'd0);
  assign data_o       = out_buf_q[0];
  assign level_o      = level;
  assign empty_o      = (level == '0);
  assign full_o       = full;
  assign overflow_o   = ovf_q;
  assign unused_rs1   = ^rs1_data;

endmodule

// File: tb/tb_fifo_sdpram_fwft.sv
// Bench for fifo_sdpram_fwft: directed scenarios plus random traffic against a queue-based model.
// Each queued word carries the cycle from which it is visible at the head (push + 3, or +1 on bypass).
module tb_fifo_sdpram_fwft;
  import fifo_sdpram_fwft_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 2;
  localparam int LVL_W = $clog2(DEPTH + 3);
`ifdef FIFO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam CsrAddrT OTHER_ADDR = 12'h123;

  logic             clk;
  logic             reset_i;
  logic             csr_enable;
  CsrAddrT          csr_addr;
  word              rs1_data;
  word              csr_data_out;
  logic             ready_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic [LVL_W-1:0] level_o;
  logic             empty_o;
  logic             full_o;
  logic             overflow_o;

  fifo_sdpram_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .csr_enable   (csr_enable),
    .csr_addr     (csr_addr),
    .rs1_data     (rs1_data),
    .csr_data_out (csr_data_out),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .level_o      (level_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .overflow_o   (overflow_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int             checks;
  int             errors;
  bit             check_en;
  int             cyc;
  bit             exp_ovf;
  logic [WIDTH-1:0] exp_q[$];
  int             vis_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit head_visible();
    return (exp_q.size() > 0) && (cyc >= vis_q[0]);
  endfunction

  function automatic word exp_status();
    word w;
    w = word'(exp_q.size());
    w[FifoStatEmptyBit] = (exp_q.size() == 0);
    w[FifoStatFullBit]  = (exp_q.size() == CAP);
    w[FifoStatOvfBit]   = exp_ovf;
    return w;
  endfunction

  task automatic check_outputs();
    chk("valid", 32'(valid_o), 32'(head_visible()));
    if (valid_o && exp_q.size() > 0) chk("data", 32'(data_o), 32'(exp_q[0]));
    chk("level", 32'(level_o), 32'(exp_q.size()));
    chk("empty", 32'(empty_o), 32'(exp_q.size() == 0));
    chk("full", 32'(full_o), 32'(exp_q.size() == CAP));
    chk("overflow", 32'(overflow_o), 32'(exp_ovf));
  endtask

  task automatic model_step(input bit rst, input bit en, input CsrAddrT addr,
                            input word wd, input bit rdy);
    bit pop, full, push_req, stat, direct;
    int lat;
    if (rst) begin
      exp_q.delete();
      vis_q.delete();
      exp_ovf = 1'b0;
    end else begin
      pop      = head_visible() && rdy;
      full     = (exp_q.size() == CAP);
      push_req = en && (addr == FifoPushCsrAddr);
      stat     = en && (addr == FifoStatusCsrAddr);
      // A direct write happens only when every queued word already sits at the output.
      direct   = BYPASS && (exp_q.size() <= 1) && ((exp_q.size() == 0) || head_visible());
      lat      = direct ? 1 : 3;
      if (pop) begin
        void'(exp_q.pop_front());
        void'(vis_q.pop_front());
      end
      if (push_req) begin
        if (!full) begin
          exp_q.push_back(wd[WIDTH-1:0]);
          vis_q.push_back(cyc + lat);
        end else begin
          exp_ovf = 1'b1;
        end
      end
      if (stat && wd[FifoStatOvfBit]) exp_ovf = 1'b0;
      if (stat && wd[FifoStatFlushBit]) begin
        exp_q.delete();
        vis_q.delete();
      end
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit rst, input bit en, input CsrAddrT addr, input word wd, input bit rdy);
    if (check_en) check_outputs();
    reset_i    = rst;
    csr_enable = en;
    csr_addr   = addr;
    rs1_data   = wd;
    ready_i    = rdy;
    #1;
    if (check_en)
      chk("csr_rd", csr_data_out, (addr == FifoStatusCsrAddr) ? exp_status() : 32'h0);
    model_step(rst, en, addr, wd, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, OTHER_ADDR, word'($urandom), rdy);
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input bit rdy);
    step(1'b0, 1'b1, FifoPushCsrAddr, {$urandom_range(0, 255), 16'h0, d} & 32'hFF00_00FF, rdy);
  endtask

  task automatic stat_wr(input word d, input bit rdy);
    step(1'b0, 1'b1, FifoStatusCsrAddr, d, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, OTHER_ADDR, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int r;
    int rdy_pct;
    word wd;
    checks = 0; errors = 0; cyc = 0; exp_ovf = 1'b0; check_en = 1'b0;
    reset_i = 1'b1; csr_enable = 1'b0; csr_addr = OTHER_ADDR; rs1_data = '0; ready_i = 1'b0;
    @(negedge clk);
    do_reset();
    check_en = 1'b1;
    do_reset();
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_empty", 32'(empty_o), 32'h1);
    chk("rst_full", 32'(full_o), 32'h0);

    // 1: first-word latency
    push(8'hA5, 1'b0);
    lat = 1;
    while (!valid_o && lat < 8) begin
      idle(1'b0);
      lat++;
    end
    chk("t1_latency", 32'(lat), BYPASS ? 32'd1 : 32'd3);
    chk("t1_data", 32'(data_o), 32'hA5);
    chk("t1_level", 32'(level_o), 32'd1);

    // 2: fill, drop, overflow W1C
    stat_wr(32'h1 << FifoStatFlushBit, 1'b0);
    for (int i = 1; i <= CAP; i++) push(WIDTH'(i), 1'b0);
    repeat (3) idle(1'b0);
    chk("t2_full", 32'(full_o), 32'h1);
    chk("t2_level", 32'(level_o), 32'(CAP));
    push(8'h77, 1'b1);
    chk("t2_ovf_set", 32'(overflow_o), 32'h1);
    chk("t2_level_after_drop", 32'(level_o), 32'(CAP - 1));
    stat_wr(32'h1 << FifoStatOvfBit, 1'b0);
    chk("t2_ovf_clr", 32'(overflow_o), 32'h0);

    // 3: drain at full rate (word 1 already left during the dropped push)
    stat_wr(32'h1 << FifoStatFlushBit, 1'b0);
    for (int i = 1; i <= CAP; i++) push(WIDTH'(i), 1'b0);
    repeat (3) idle(1'b0);
    for (int i = 1; i <= CAP; i++) begin
      chk("t3_seq", valid_o ? 32'(data_o) : 32'hDEAD, 32'(i));
      idle(1'b1);
    end
    chk("t3_empty", 32'(empty_o), 32'h1);

    // 4: steady push+pop across several pointer wraps
    for (int i = 0; i < 3; i++) push(8'hE0 + WIDTH'(i), 1'b0);
    repeat (3) idle(1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      chk("t4_level", 32'(level_o), 32'd3);
      push(WIDTH'($urandom), 1'b1);
    end

    // 5: flush with a read in flight
    stat_wr(32'h1 << FifoStatFlushBit, 1'b0);
    for (int i = 0; i < 5; i++) push(8'h50 + WIDTH'(i), 1'b0);
    stat_wr(32'h1 << FifoStatFlushBit, 1'b0);
    chk("t5_valid", 32'(valid_o), 32'h0);
    chk("t5_level", 32'(level_o), 32'h0);
    push(8'h3C, 1'b0);
    lat = 1;
    while (!valid_o && lat < 8) begin
      idle(1'b0);
      lat++;
    end
    chk("t5_next", 32'(data_o), 32'h3C);

    // 6: reset mid-stream, overflow also pending
    for (int i = 0; i < CAP + 2; i++) push(8'h90 + WIDTH'(i), 1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 4; i++) push(8'hC0 + WIDTH'(i), 1'b0);
    do_reset();
    chk("t6_valid", 32'(valid_o), 32'h0);
    chk("t6_data", 32'(data_o), 32'h0);
    chk("t6_level", 32'(level_o), 32'h0);
    chk("t6_ovf", 32'(overflow_o), 32'h0);
    repeat (5) begin
      chk("t6_no_old", 32'(valid_o), 32'h0);
      idle(1'b1);
    end

    // random traffic
    rdy_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) rdy_pct = $urandom_range(5, 100);
      r = $urandom_range(0, 999);
      if (r < 550) begin
        push(WIDTH'($urandom), 1'($urandom_range(1, 100) <= rdy_pct));
      end else if (r < 600) begin
        wd = $urandom & ~(32'h1 << FifoStatFlushBit);
        if ($urandom_range(0, 5) == 0) wd[FifoStatFlushBit] = 1'b1;
        stat_wr(wd, 1'($urandom_range(1, 100) <= rdy_pct));
      end else if (r < 650) begin
        step(1'b0, 1'b0, FifoStatusCsrAddr, word'($urandom), 1'($urandom_range(1, 100) <= rdy_pct));
      end else if (r < 665) begin
        step(1'b0, 1'b1, OTHER_ADDR, word'($urandom), 1'($urandom_range(1, 100) <= rdy_pct));
      end else if (r < 669) begin
        do_reset();
      end else begin
        idle(1'($urandom_range(1, 100) <= rdy_pct));
      end
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
